// File: rtl/audio_route_ctrl.sv
// Click-free audio source selector: debounced request, fade-out, swap at zero gain,
// fade-in. All sequencing advances only on sample_strobe.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// PASS     | unity gain on sel_active; debounce new requests
// FADE_OUT | ramp gain down one step per strobe toward zero
// SWAP     | one strobe at zero gain; route switches to target
// FADE_IN  | ramp gain up one step per strobe back to unity
module audio_route_ctrl #(
  parameter int DATA_W     = 16,
  parameter int RAMP_SHIFT = 5,
  parameter int DEBOUNCE_N = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_strobe,
  input  logic [1:0]        sel_req,
  input  logic [DATA_W-1:0] x_bypass,
  input  logic [DATA_W-1:0] x_fir,
  input  logic [DATA_W-1:0] x_iir,
  output logic [DATA_W-1:0] y_out,
  output logic              y_valid,
  output logic [1:0]        sel_active,
  output logic              busy
);

  localparam int GAIN_W = RAMP_SHIFT + 1;
  localparam int PROD_W = DATA_W + RAMP_SHIFT + 2;
  localparam int DEB_W  = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;

  localparam logic [GAIN_W-1:0] GAIN_MAX  = {1'b1, {RAMP_SHIFT{1'b0}}};
  localparam logic [GAIN_W-1:0] GAIN_ONE  = GAIN_W'(1);
  localparam logic [GAIN_W-1:0] GAIN_ZERO = '0;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_N - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);

  typedef enum logic [1:0] {
    ST_PASS     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_SWAP     = 2'd2,
    ST_FADE_IN  = 2'd3
  } state_t;

  state_t              state_q,      state_d;
  logic [1:0]          sync1_q,      sync1_d;
  logic [1:0]          sync2_q,      sync2_d;
  logic [1:0]          req_prev_q,   req_prev_d;
  logic [1:0]          target_q,     target_d;
  logic [1:0]          sel_active_q, sel_active_d;
  logic [GAIN_W-1:0]   gain_q,       gain_d;
  logic [DEB_W-1:0]    deb_cnt_q,    deb_cnt_d;
  logic [DATA_W-1:0]   y_out_q,      y_out_d;
  logic                y_valid_q,    y_valid_d;
  logic                busy_q,       busy_d;

  logic [1:0]          req_n;
  logic [DATA_W-1:0]   x_sel;
  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] g_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] prod_shr;
  logic                unused_prod;

  // Code 11 is not a real source; treat it as bypass.
  assign req_n = (sync2_q == 2'b11) ? 2'b00 : sync2_q;

  always_comb begin
    case (sel_active_q)
      2'b01:   x_sel = x_fir;
      2'b10:   x_sel = x_iir;
      default: x_sel = x_bypass;
    endcase
  end

  // Gain is never negative, so it is zero-extended; the shift floors toward -inf.
  always_comb begin
    x_ext    = {{(PROD_W - DATA_W){x_sel[DATA_W-1]}}, x_sel};
    g_ext    = {{(PROD_W - GAIN_W){1'b0}}, gain_q};
    prod     = x_ext * g_ext;
    prod_shr = prod >>> RAMP_SHIFT;
  end

  assign unused_prod = ^{prod_shr[PROD_W-1:DATA_W]};

  always_comb begin
    state_d      = state_q;
    sync1_d      = sel_req;
    sync2_d      = sync1_q;
    req_prev_d   = req_prev_q;
    target_d     = target_q;
    sel_active_d = sel_active_q;
    gain_d       = gain_q;
    deb_cnt_d    = deb_cnt_q;
    y_out_d      = y_out_q;
    y_valid_d    = sample_strobe;

    if (sample_strobe) begin
      y_out_d = prod_shr[DATA_W-1:0];

      case (state_q)
        ST_PASS: begin
          gain_d     = GAIN_MAX;
          req_prev_d = req_n;
          if ((req_n != sel_active_q) && (req_n == req_prev_q)) begin
            if (deb_cnt_q == DEB_LAST) begin
              target_d  = req_n;
              deb_cnt_d = '0;
              state_d   = ST_FADE_OUT;
            end else begin
              deb_cnt_d = deb_cnt_q + DEB_ONE;
            end
          end else begin
            deb_cnt_d = '0;
          end
        end

        ST_FADE_OUT: begin
          deb_cnt_d = '0;
          if (gain_q == GAIN_ONE) begin
            gain_d  = GAIN_ZERO;
            state_d = ST_SWAP;
          end else begin
            gain_d = gain_q - GAIN_ONE;
          end
        end

        ST_SWAP: begin
          deb_cnt_d    = '0;
          gain_d       = GAIN_ZERO;
          sel_active_d = target_q;
          state_d      = ST_FADE_IN;
        end

        ST_FADE_IN: begin
          deb_cnt_d = '0;
          if (gain_q == (GAIN_MAX - GAIN_ONE)) begin
            gain_d  = GAIN_MAX;
            state_d = ST_PASS;
          end else begin
            gain_d = gain_q + GAIN_ONE;
          end
        end

        default: begin
          state_d = ST_PASS;
          gain_d  = GAIN_MAX;
        end
      endcase
    end

    busy_d = (state_d != ST_PASS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_PASS;
      sync1_q      <= 2'b00;
      sync2_q      <= 2'b00;
      req_prev_q   <= 2'b00;
      target_q     <= 2'b00;
      sel_active_q <= 2'b00;
      gain_q       <= GAIN_MAX;
      deb_cnt_q    <= '0;
      y_out_q      <= '0;
      y_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      req_prev_q   <= req_prev_d;
      target_q     <= target_d;
      sel_active_q <= sel_active_d;
      gain_q       <= gain_d;
      deb_cnt_q    <= deb_cnt_d;
      y_out_q      <= y_out_d;
      y_valid_q    <= y_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign y_out      = y_out_q;
  assign y_valid    = y_valid_q;
  assign sel_active = sel_active_q;
  assign busy       = busy_q;

endmodule
